// File: rtl/tx_pkg.sv
// Shared definitions for the transmit word scheduler: ASCII constants,
// FSM state encoding and the nibble-to-hex-character helper.
package tx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0d;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_NIB  = 2'd2,
    ST_TERM = 2'd3
  } sched_state_e;

  // Uppercase hex character for one nibble ('0'..'9', 'A'..'F').
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n <= 4'd9) hex_ascii = ASCII_0 + {4'h0, n};
    else           hex_ascii = ASCII_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: picks the first set request strictly after ptr,
// wrapping modulo N, so the last winner drops to lowest priority.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] sel,
  output logic          any
);

  // Scan N positions starting one past the pointer; first hit wins.
  always_comb begin
    int idx;
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/tx_word_scheduler.sv
// Shares one byte-serial transmitter between CHANNELS word sources.
// A granted word goes out as [tag char] + hex nibbles MSB first + TERMINATOR.
module tx_word_scheduler
  import tx_pkg::*;
#(
  parameter int         CHANNELS   = 4,
  parameter int         RESOLUTION = 32,
  parameter bit         TAG_EN     = 1'b1,
  parameter logic [7:0] TERMINATOR = ASCII_CR,
  localparam int        NIBBLES    = RESOLUTION / 4,
  localparam int        IW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [CHANNELS-1:0]            req,
  input  logic [CHANNELS*RESOLUTION-1:0] data,
  output logic [CHANNELS-1:0]            ack,
  output logic [7:0]                     tx_byte,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           busy,
  output logic [IW-1:0]                  grant_idx
);

  localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  sched_state_e          state_q, state_d;
  logic [RESOLUTION-1:0] word_q, word_d;
  logic [NW-1:0]         nib_q, nib_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [CHANNELS-1:0]   ack_q, ack_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q, busy_d;

  logic [IW-1:0]         sel;
  logic                  any;
  logic [RESOLUTION-1:0] sel_word;
  logic [NW-1:0]         nib_m1;
  logic                  tx_accept;

  rr_arbiter #(.N(CHANNELS), .PW(IW)) u_arb (
    .req (req),
    .ptr (rr_ptr_q),
    .sel (sel),
    .any (any)
  );

  assign sel_word  = data[sel*RESOLUTION +: RESOLUTION];
  assign nib_m1    = nib_q - NW'(1);
  assign tx_accept = tx_valid_q && tx_ready;

  // Next-state: grant and capture in IDLE, then walk tag/nibbles/terminator one byte per accept.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    nib_d      = nib_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && any) begin
          word_d     = sel_word;
          ack_d[sel] = 1'b1;
          grant_d    = sel;
          rr_ptr_d   = sel;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          nib_d      = NW'(NIBBLES - 1);
          if (TAG_EN) begin
            state_d   = ST_TAG;
            tx_byte_d = hex_ascii(4'(sel));
          end else begin
            state_d   = ST_NIB;
            tx_byte_d = hex_ascii(sel_word[RESOLUTION-1 -: 4]);
          end
        end
      end
      ST_TAG: begin
        if (tx_accept) begin
          state_d   = ST_NIB;
          nib_d     = NW'(NIBBLES - 1);
          tx_byte_d = hex_ascii(word_q[RESOLUTION-1 -: 4]);
        end
      end
      ST_NIB: begin
        if (tx_accept) begin
          if (nib_q == '0) begin
            state_d   = ST_TERM;
            tx_byte_d = TERMINATOR;
          end else begin
            nib_d     = nib_m1;
            tx_byte_d = hex_ascii(word_q[nib_m1*4 +: 4]);
          end
        end
      end
      ST_TERM: begin
        // Dropping valid here guarantees one idle cycle before the next word.
        if (tx_accept) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      nib_q      <= '0;
      rr_ptr_q   <= IW'(CHANNELS - 1);
      grant_q    <= '0;
      ack_q      <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      nib_q      <= nib_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign tx_byte   = tx_byte_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_tx_word_scheduler.sv
// Scoreboard bench: the driver predicts grants and byte strings from the
// arbitration rules; an independent monitor pops and compares on every
// ack pulse and every accepted byte.
module tb_tx_word_scheduler;

  localparam int CH = 4;
  localparam int RES = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic [CH-1:0]     req = '0;
  logic [CH*RES-1:0] data;
  logic [CH-1:0]     ack;
  logic [7:0]        tx_byte;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              busy;
  logic [1:0]        grant_idx;

  logic [RES-1:0] data_r [CH];
  assign data = {data_r[3], data_r[2], data_r[1], data_r[0]};

  tx_word_scheduler #(.CHANNELS(CH), .RESOLUTION(RES), .TAG_EN(1'b1), .TERMINATOR(8'h0d)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .data(data), .ack(ack),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int last_grant = CH - 1;
  int last_lat = 0;
  int tx_mode = 0;       // 0: ready=1, 1: toggle, 2: random
  int acc_cnt = 0, busy_cnt = 0, valid_cnt = 0, ack_cnt = 0;
  int exp_grant [$];
  logic [7:0] exp_bytes [$];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_byte = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input int n);
    string hs;
    hs = "0123456789ABCDEF";
    return hs[n];
  endfunction

  // Next winner: first requester after the previous winner, wrapping.
  function automatic int model_pick(input logic [CH-1:0] m, input int last);
    for (int k = 1; k <= CH; k++)
      if (m[(last + k) % CH]) return (last + k) % CH;
    return -1;
  endfunction

  // Transmitter readiness pattern.
  always @(posedge clk) begin
    #1;
    case (tx_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compare every ack and every accepted byte against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (tx_valid) valid_cnt++;
      if (ack != '0) begin
        ack_cnt++;
        if (exp_grant.size() == 0) chk("extra_ack", exp_grant.size(), 1);
        else begin
          int g;
          g = exp_grant.pop_front();
          chk("ack_onehot", ack, 1 << g);
          chk("grant_idx", grant_idx, g);
        end
      end
      if (tx_valid && hold_pend) chk("byte_stable", tx_byte, hold_byte);
      if (tx_valid && tx_ready) begin
        acc_cnt++;
        if (exp_bytes.size() == 0) chk("extra_byte", exp_bytes.size(), 1);
        else chk("tx_byte", tx_byte, exp_bytes.pop_front());
      end
      hold_pend = tx_valid && !tx_ready;
      hold_byte = tx_byte;
    end
  end

  // Predict the grant for the current mask, wait for its ack, then apply the next mask.
  task automatic run_word(input logic [CH-1:0] nxt, input bit chg, output int got);
    int w, n;
    logic [RES-1:0] wd;
    got = -1;
    w = model_pick(req, last_grant);
    if (w >= 0) begin
      wd = data_r[w];
      exp_grant.push_back(w);
      exp_bytes.push_back(hexc(w));
      for (int i = RES/4 - 1; i >= 0; i--) exp_bytes.push_back(hexc(int'((wd >> (4*i)) & 32'hF)));
      exp_bytes.push_back(8'h0d);
      last_grant = w;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (ack == '0 && n < 300);
    last_lat = n;
    if (ack == '0) chk("ack_timeout", n, 0);
    else for (int i = 0; i < CH; i++) if (ack[i]) got = i;
    @(posedge clk); #1;
    if (chg && w >= 0) begin
      data_r[w] = $urandom;
      for (int i = 0; i < CH; i++) if (!nxt[i]) data_r[i] = $urandom;
    end
    req = nxt;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); #1; n++; end while ((busy || exp_bytes.size() != 0) && n < 500);
    if (n >= 500) chk("idle_timeout", busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    last_grant = CH - 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, b0, v0, a0, base;
    int rr_order [6] = '{0, 1, 2, 3, 0, 1};
    logic [CH-1:0] rr_mask [6] = '{4'hF, 4'hF, 4'hF, 4'h9, 4'hF, 4'h0};
    for (int i = 0; i < CH; i++) data_r[i] = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_grant_idx", grant_idx, 0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single word on channel 2.
    data_r[2] = 32'h1234ABCD;
    req = 4'b0100;
    b0 = busy_cnt; v0 = valid_cnt;
    run_word(4'h0, 1'b0, g);
    chk("single_grant", g, 2);
    chk("single_latency", last_lat, 2);
    wait_idle();
    chk("single_busy_span", busy_cnt - b0, 10);
    chk("single_valid_span", valid_cnt - v0, 10);

    // Backpressure with toggling ready.
    tx_mode = 1;
    data_r[0] = 32'h0000000F;
    req = 4'b0001;
    run_word(4'h0, 1'b0, g);
    chk("bp_grant", g, 0);
    wait_idle();
    tx_mode = 0;

    // Round robin from reset.
    do_reset();
    req = 4'hF;
    for (int i = 0; i < 6; i++) begin
      run_word(rr_mask[i], 1'b0, g);
      chk("rr_order", g, rr_order[i]);
    end
    wait_idle();

    // Capture isolation: data0 changes and req0 drops right after ack.
    data_r[0] = 32'hC0FFEE01;
    req = 4'b0001;
    run_word(4'h0, 1'b1, g);
    chk("iso_grant", g, 0);
    wait_idle();
    a0 = ack_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("iso_no_regrant", ack_cnt - a0, 0);

    // Enable low blocks grants.
    enable = 1'b0;
    req = 4'hF;
    a0 = ack_cnt; v0 = valid_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("en0_no_ack", ack_cnt - a0, 0);
    chk("en0_no_valid", valid_cnt - v0, 0);

    // Reset mid-word after the third nibble.
    base = acc_cnt;
    enable = 1'b1;
    run_word(4'h0, 1'b0, g);
    chk("en1_latency", last_lat, 2);
    for (int n = 0; n < 300 && acc_cnt < base + 4; n++) begin @(negedge clk); #1; end
    chk("pre_reset_bytes", acc_cnt - base, 4);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_bytes.delete();
    exp_grant.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", ack, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_grant = CH - 1;
    req = 4'hF;
    run_word(4'h0, 1'b0, g);
    chk("post_reset_first", g, 0);
    wait_idle();

    // Randomized traffic with random backpressure.
    tx_mode = 2;
    for (int i = 0; i < CH; i++) data_r[i] = $urandom;
    req = CH'($urandom_range(1, 15));
    for (int it = 0; it < 40; it++) begin
      run_word((it == 39) ? 4'h0 : CH'($urandom_range(1, 15)), 1'b1, g);
    end
    wait_idle();
    tx_mode = 0;

    chk("grant_q_empty", exp_grant.size(), 0);
    chk("byte_q_empty", exp_bytes.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
